// File: rtl/fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_detect
// Brief    : Squared-magnitude stream and windowed peak search over one
//            FFT output burst; one peak result (or frame_err) per frame.
// Revision : 1.0  initial release
// ============================================================================
module fft_peak_detect #(
   parameter int NBINS       = 64,
   parameter int SKIP_CYCLES = 1,
   parameter int SEARCH_LO   = 1,
   parameter int SEARCH_HI   = 31,
   localparam int IW         = $clog2(NBINS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_en,
   input  logic [7:0]    in_r,
   input  logic [7:0]    in_i,
   output logic          mag_valid,
   output logic [15:0]   mag,
   output logic [IW-1:0] mag_idx,
   output logic          peak_valid,
   output logic [IW-1:0] peak_idx,
   output logic [15:0]   peak_mag,
   output logic          frame_err,
   output logic          busy
);

   localparam int SKW = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES + 1) : 1;
   localparam logic [IW-1:0]  c_last_bin  = IW'(NBINS - 1);
   localparam logic [IW-1:0]  c_lo        = IW'(SEARCH_LO);
   localparam logic [IW-1:0]  c_hi        = IW'(SEARCH_HI);
   localparam logic [SKW-1:0] c_skip_last = SKW'(SKIP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SKIP    = 3'd1,
      S_COLLECT = 3'd2,
      S_REPORT  = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t           r_state, w_state_next;
   logic             r_in_en_d;
   logic             r_armed;
   logic [SKW-1:0]   r_skip_cnt, w_skip_cnt_next;
   logic [IW-1:0]    r_bin_cnt, w_bin_next;
   logic             w_start, w_accept, w_abort;

   logic             r_mag_valid;
   logic [15:0]      r_mag;
   logic [IW-1:0]    r_mag_idx;
   logic [15:0]      r_best_mag, w_best_mag;
   logic [IW-1:0]    r_best_idx, w_best_idx;
   logic             r_peak_valid;
   logic [IW-1:0]    r_peak_idx;
   logic [15:0]      r_peak_mag;
   logic             r_frame_err;

   logic signed [15:0] w_sq_r, w_sq_i;
   logic [15:0]        w_mag_sum;

   // Start detection stays disarmed after reset until in_en is seen low, so a
   // burst already in flight at reset release cannot look like a rising edge.
   assign w_start = in_en & ~r_in_en_d & r_armed;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_in_en_d  <= 1'b0;
         r_armed    <= 1'b0;
         r_skip_cnt <= '0;
         r_bin_cnt  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_in_en_d  <= in_en;
         r_armed    <= r_armed | ~in_en;
         r_skip_cnt <= w_skip_cnt_next;
         r_bin_cnt  <= w_bin_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_skip_cnt_next = r_skip_cnt;
      w_bin_next      = r_bin_cnt;
      w_accept        = 1'b0;
      w_abort         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_skip_cnt_next = SKW'(1);
               w_bin_next      = '0;
               w_state_next    = (SKIP_CYCLES > 1) ? S_SKIP : S_COLLECT;
            end
         end
         S_SKIP: begin
            if (!in_en) begin
               w_abort      = 1'b1;
               w_state_next = S_IDLE;
            end else if (r_skip_cnt == c_skip_last) begin
               w_state_next = S_COLLECT;
            end else begin
               w_skip_cnt_next = r_skip_cnt + 1'b1;
            end
         end
         S_COLLECT: begin
            if (!in_en) begin
               w_abort      = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_accept   = 1'b1;
               w_bin_next = r_bin_cnt + 1'b1;
               if (r_bin_cnt == c_last_bin)
                  w_state_next = S_REPORT;
            end
         end
         S_REPORT: w_state_next = S_DRAIN;
         S_DRAIN: begin
            if (!in_en)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_sq_r    = $signed(in_r) * $signed(in_r);
   assign w_sq_i    = $signed(in_i) * $signed(in_i);
   assign w_mag_sum = $unsigned(w_sq_r) + $unsigned(w_sq_i);

   // Running best: loaded at SEARCH_LO, replaced only on strictly larger mag.
   always_comb begin
      w_best_mag = r_best_mag;
      w_best_idx = r_best_idx;
      if (r_mag_valid) begin
         if (r_mag_idx == c_lo) begin
            w_best_mag = r_mag;
            w_best_idx = r_mag_idx;
         end else if ((r_mag_idx > c_lo) && (r_mag_idx <= c_hi) &&
                      (r_mag > r_best_mag)) begin
            w_best_mag = r_mag;
            w_best_idx = r_mag_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mag_valid  <= 1'b0;
         r_mag        <= '0;
         r_mag_idx    <= '0;
         r_best_mag   <= '0;
         r_best_idx   <= '0;
         r_peak_valid <= 1'b0;
         r_peak_idx   <= '0;
         r_peak_mag   <= '0;
         r_frame_err  <= 1'b0;
      end else begin
         r_mag_valid  <= w_accept;
         if (w_accept) begin
            r_mag     <= w_mag_sum;
            r_mag_idx <= r_bin_cnt;
         end
         r_best_mag   <= w_best_mag;
         r_best_idx   <= w_best_idx;
         // REPORT coincides with the final bin on the mag stream, so the
         // combinational best already includes it.
         r_peak_valid <= (r_state == S_REPORT);
         if (r_state == S_REPORT) begin
            r_peak_idx <= w_best_idx;
            r_peak_mag <= w_best_mag;
         end
         r_frame_err  <= w_abort;
      end
   end

   assign mag_valid  = r_mag_valid;
   assign mag        = r_mag;
   assign mag_idx    = r_mag_idx;
   assign peak_valid = r_peak_valid;
   assign peak_idx   = r_peak_idx;
   assign peak_mag   = r_peak_mag;
   assign frame_err  = r_frame_err;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_peak_detect
// Brief    : Directed self-checking bench for fft_peak_detect.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_peak_detect;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_en;
   logic [7:0]  in_r, in_i;
   logic        mag_valid, peak_valid, frame_err, busy;
   logic [15:0] mag, peak_mag;
   logic [5:0]  mag_idx, peak_idx;

   int checks = 0;
   int errors = 0;

   fft_peak_detect dut (
      .clk        (clk),
      .rst        (rst),
      .in_en      (in_en),
      .in_r       (in_r),
      .in_i       (in_i),
      .mag_valid  (mag_valid),
      .mag        (mag),
      .mag_idx    (mag_idx),
      .peak_valid (peak_valid),
      .peak_idx   (peak_idx),
      .peak_mag   (peak_mag),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive monitor on the falling edge; only ever accumulates.
   logic [15:0] cap_mag [64];
   logic [5:0]  pv_log_idx [16];
   logic [15:0] pv_log_mag [16];
   int mv_cnt = 0, pv_cnt = 0, fe_cnt = 0, bsy_cnt = 0, pv_cyc = 0;
   always @(negedge clk) begin
      if (mag_valid) begin
         cap_mag[mag_idx] <= mag;
         mv_cnt <= mv_cnt + 1;
      end
      if (peak_valid) begin
         pv_log_idx[pv_cnt % 16] <= peak_idx;
         pv_log_mag[pv_cnt % 16] <= peak_mag;
         pv_cnt <= pv_cnt + 1;
         pv_cyc <= cyc;
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (busy) bsy_cnt <= bsy_cnt + 1;
   end

   logic [7:0] fr_r [64];
   logic [7:0] fr_i [64];

   task automatic clear_frame();
      for (int k = 0; k < 64; k++) begin
         fr_r[k] = 8'd0;
         fr_i[k] = 8'd0;
      end
   endtask

   task automatic set_bin(input int k, input int r, input int i);
      fr_r[k] = 8'(r);
      fr_i[k] = 8'(i);
   endtask

   task automatic drive(input logic en, input logic [7:0] r, input logic [7:0] i);
      @(posedge clk);
      #1;
      in_en = en;
      in_r  = r;
      in_i  = i;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'd0, 8'd0);
      @(negedge clk);
      #1;
   endtask

   // Lead cycle, nb bins, optional repeat of the last bin, then one low cycle.
   task automatic run_frame(input int nb, input bit tail, output int last_cyc);
      drive(1'b1, 8'd0, 8'd0);
      for (int k = 0; k < nb; k++) drive(1'b1, fr_r[k], fr_i[k]);
      last_cyc = cyc;
      if (tail) drive(1'b1, fr_r[nb-1], fr_i[nb-1]);
      drive(1'b0, 8'd0, 8'd0);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_en = 1'b0; in_r = 8'd0; in_i = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({mag_valid, peak_valid, frame_err, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {mag_valid, peak_valid, frame_err, busy});
      end
      checks++;
      if ({mag, peak_mag, mag_idx, peak_idx} !== 44'd0) begin
         errors++;
         $display("FAIL reset_data: got mag=%0d peak_mag=%0d mag_idx=%0d peak_idx=%0d expected all 0",
                  mag, peak_mag, mag_idx, peak_idx);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
   endtask

   task automatic test_single_tone();
      int m0, p0, f0, b0, lc;
      clear_frame();
      set_bin(5, 10, -3);
      m0 = mv_cnt; p0 = pv_cnt; f0 = fe_cnt; b0 = bsy_cnt;
      run_frame(64, 1'b1, lc);
      idle(4);
      checks++;
      if (mv_cnt - m0 !== 64) begin
         errors++; $display("FAIL tone_mag_valid_count: got %0d expected 64", mv_cnt - m0);
      end
      checks++;
      if (cap_mag[5] !== 16'd109) begin
         errors++; $display("FAIL tone_mag5: got %0d expected 109", cap_mag[5]);
      end
      checks++;
      if (cap_mag[4] !== 16'd0) begin
         errors++; $display("FAIL tone_mag4: got %0d expected 0", cap_mag[4]);
      end
      checks++;
      if (pv_cnt - p0 !== 1) begin
         errors++; $display("FAIL tone_peak_count: got %0d expected 1", pv_cnt - p0);
      end
      checks++;
      if (pv_cyc !== lc + 2) begin
         errors++; $display("FAIL tone_peak_latency: got cycle %0d expected %0d", pv_cyc, lc + 2);
      end
      checks++;
      if (peak_idx !== 6'd5 || peak_mag !== 16'd109) begin
         errors++; $display("FAIL tone_peak: got idx=%0d mag=%0d expected idx=5 mag=109", peak_idx, peak_mag);
      end
      checks++;
      if (busy !== 1'b0 || bsy_cnt - b0 !== 66) begin
         errors++; $display("FAIL tone_busy: got busy=%b cycles=%0d expected busy=0 cycles=66", busy, bsy_cnt - b0);
      end
      checks++;
      if (fe_cnt - f0 !== 0) begin
         errors++; $display("FAIL tone_frame_err: got %0d expected 0", fe_cnt - f0);
      end
   endtask

   task automatic test_early_end();
      int m0, p0, f0, lc;
      clear_frame();
      set_bin(2, 50, 50);
      m0 = mv_cnt; p0 = pv_cnt; f0 = fe_cnt;
      run_frame(20, 1'b0, lc);
      idle(4);
      checks++;
      if (fe_cnt - f0 !== 1 || pv_cnt - p0 !== 0) begin
         errors++; $display("FAIL early_pulses: got frame_err=%0d peak_valid=%0d expected 1 and 0",
                            fe_cnt - f0, pv_cnt - p0);
      end
      checks++;
      if (mv_cnt - m0 !== 20) begin
         errors++; $display("FAIL early_mag_count: got %0d expected 20", mv_cnt - m0);
      end
      checks++;
      if (peak_idx !== 6'd5 || peak_mag !== 16'd109 || busy !== 1'b0) begin
         errors++; $display("FAIL early_hold: got idx=%0d mag=%0d busy=%b expected idx=5 mag=109 busy=0",
                            peak_idx, peak_mag, busy);
      end
   endtask

   task automatic test_tie_window();
      int m0, p0, lc;
      clear_frame();
      set_bin(3, 4, 0);
      set_bin(7, 4, 0);
      set_bin(0, 100, 100);
      set_bin(40, 127, 127);
      m0 = mv_cnt; p0 = pv_cnt;
      run_frame(64, 1'b1, lc);
      idle(4);
      checks++;
      if (peak_idx !== 6'd3 || peak_mag !== 16'd16 || pv_cnt - p0 !== 1) begin
         errors++; $display("FAIL tie_peak: got idx=%0d mag=%0d pulses=%0d expected idx=3 mag=16 pulses=1",
                            peak_idx, peak_mag, pv_cnt - p0);
      end
      checks++;
      if (cap_mag[0] !== 16'd20000 || cap_mag[40] !== 16'd32258) begin
         errors++; $display("FAIL tie_stream: got mag0=%0d mag40=%0d expected 20000 and 32258",
                            cap_mag[0], cap_mag[40]);
      end
      checks++;
      if (cap_mag[7] !== 16'd16 || mv_cnt - m0 !== 64) begin
         errors++; $display("FAIL tie_stream7: got mag7=%0d count=%0d expected 16 and 64", cap_mag[7], mv_cnt - m0);
      end
   endtask

   task automatic test_extremes();
      int lc;
      clear_frame();
      set_bin(20, -128, -128);
      run_frame(64, 1'b1, lc);
      idle(3);
      checks++;
      if (peak_idx !== 6'd20 || peak_mag !== 16'd32768 || cap_mag[20] !== 16'd32768) begin
         errors++; $display("FAIL extreme_peak: got idx=%0d mag=%0d stream=%0d expected idx=20 mag=32768",
                            peak_idx, peak_mag, cap_mag[20]);
      end
      clear_frame();
      run_frame(64, 1'b1, lc);
      idle(3);
      checks++;
      if (peak_idx !== 6'd1 || peak_mag !== 16'd0) begin
         errors++; $display("FAIL zero_peak: got idx=%0d mag=%0d expected idx=1 mag=0", peak_idx, peak_mag);
      end
   endtask

   task automatic test_reset_mid_frame();
      int m0, p0, f0, lc;
      clear_frame();
      set_bin(12, 5, 5);
      drive(1'b1, 8'd0, 8'd0);
      for (int k = 0; k < 30; k++) drive(1'b1, fr_r[k], fr_i[k]);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mag_valid, peak_valid, frame_err, busy} !== 4'b0000 ||
          {mag, peak_mag, mag_idx, peak_idx} !== 44'd0) begin
         errors++; $display("FAIL midreset_outputs: got flags=%b mag=%0d peak_idx=%0d peak_mag=%0d expected all 0",
                            {mag_valid, peak_valid, frame_err, busy}, mag, peak_idx, peak_mag);
      end
      m0 = 0; p0 = 0; f0 = 0;
      for (int k = 30; k < 64; k++) begin
         drive(1'b1, fr_r[k], fr_i[k]);
         if (k == 32) begin
            rst = 1'b0;
            m0 = mv_cnt; p0 = pv_cnt; f0 = fe_cnt;
         end
      end
      drive(1'b1, fr_r[63], fr_i[63]);
      idle(5);
      checks++;
      if (mv_cnt - m0 !== 0 || pv_cnt - p0 !== 0 || fe_cnt - f0 !== 0) begin
         errors++; $display("FAIL midreset_ignored: got mag_valid=%0d peak_valid=%0d frame_err=%0d expected 0 0 0",
                            mv_cnt - m0, pv_cnt - p0, fe_cnt - f0);
      end
      checks++;
      if (busy !== 1'b0 || peak_idx !== 6'd0 || peak_mag !== 16'd0) begin
         errors++; $display("FAIL midreset_state: got busy=%b idx=%0d mag=%0d expected 0 0 0", busy, peak_idx, peak_mag);
      end
      m0 = mv_cnt; p0 = pv_cnt;
      run_frame(64, 1'b1, lc);
      idle(3);
      checks++;
      if (peak_idx !== 6'd12 || peak_mag !== 16'd50 || pv_cnt - p0 !== 1 || mv_cnt - m0 !== 64) begin
         errors++; $display("FAIL postreset_frame: got idx=%0d mag=%0d pulses=%0d bins=%0d expected 12 50 1 64",
                            peak_idx, peak_mag, pv_cnt - p0, mv_cnt - m0);
      end
   endtask

   task automatic test_back_to_back();
      int p0, m0, lca, lcb;
      p0 = pv_cnt; m0 = mv_cnt;
      clear_frame();
      set_bin(9, 3, 4);
      run_frame(64, 1'b1, lca);
      clear_frame();
      set_bin(17, -7, 2);
      run_frame(64, 1'b1, lcb);
      idle(3);
      checks++;
      if (pv_cnt - p0 !== 2 || mv_cnt - m0 !== 128) begin
         errors++; $display("FAIL b2b_counts: got pulses=%0d bins=%0d expected 2 and 128", pv_cnt - p0, mv_cnt - m0);
      end
      checks++;
      if (pv_log_idx[p0 % 16] !== 6'd9 || pv_log_mag[p0 % 16] !== 16'd25) begin
         errors++; $display("FAIL b2b_first: got idx=%0d mag=%0d expected idx=9 mag=25",
                            pv_log_idx[p0 % 16], pv_log_mag[p0 % 16]);
      end
      checks++;
      if (pv_log_idx[(p0 + 1) % 16] !== 6'd17 || pv_log_mag[(p0 + 1) % 16] !== 16'd53 || pv_cyc !== lcb + 2) begin
         errors++; $display("FAIL b2b_second: got idx=%0d mag=%0d cycle=%0d expected idx=17 mag=53 cycle=%0d",
                            pv_log_idx[(p0 + 1) % 16], pv_log_mag[(p0 + 1) % 16], pv_cyc, lcb + 2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_tone();
      test_early_end();
      test_tie_window();
      test_extremes();
      test_reset_mid_frame();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
